mult_display: RTL and testbench

//  Downstream stage of the sequential multiplier. Captures the product when the multiplier's done rises.

---
 rtl/mult_display_if.sv | 37 +++
 rtl/mult_display.sv | 205 ++++++++++++++++++++
 tb/tb_mult_display.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mult_display_if.sv
// Interface: mult_display_if
// Bundles the product handoff from the multiplier with the converted value
// and the display pins, so the display stage takes one port for all of them.
//   master : the multiplier/board side. Drives result/done and sees the
//            BCD value and the display pins.
//   slave  : mult_display. Takes result/done and drives bcd, bcd_valid,
//            busy, seg and an.
// Signals:
//   result    [WIDTH-1:0]    product from the multiplier
//   done                     completion level; a rising edge means a new product
//   bcd       [4*DIGITS-1:0] converted value; digit 0 (ones) is in [3:0]
//   bcd_valid                one-cycle pulse when bcd has just been updated
//   busy                     a conversion is in progress
//   seg       [6:0]          segments {g,f,e,d,c,b,a}, active-low
//   an        [DIGITS-1:0]   digit enables, active-low one-hot
interface mult_display_if #(
  parameter int WIDTH  = 6,
  parameter int DIGITS = 2
) ();
  logic [WIDTH-1:0]    result;
  logic                done;
  logic [4*DIGITS-1:0] bcd;
  logic                bcd_valid;
  logic                busy;
  logic [6:0]          seg;
  logic [DIGITS-1:0]   an;

  modport master (
    output result, done,
    input  bcd, bcd_valid, busy, seg, an
  );

  modport slave (
    input  result, done,
    output bcd, bcd_valid, busy, seg, an
  );
endinterface

// File: rtl/mult_display.sv
// Module: mult_display
// Display stage that follows the sequential multiplier. It captures the
// product on each rising edge of done. It converts the product to BCD with a
// double-dabble that does one shift per clock. It shows the result on a
// time-multiplexed, active-low, common-anode 7-segment display.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : mult_display_if.slave
//          inputs  result, done
//          outputs bcd, bcd_valid, busy, seg, an
// Parameters:
//   WIDTH       : product width; requires 10**DIGITS > 2**WIDTH-1
//   DIGITS      : number of BCD digits
//   REFRESH_DIV : clock cycles each digit stays lit (>=2)
//   BLANK_LZ    : 1 blanks leading zero digits. Digit 0 is never blanked.
module mult_display #(
  parameter int WIDTH       = 6,
  parameter int DIGITS      = 2,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_LZ    = 1
) (
  input  logic           clk,
  input  logic           rst,
  mult_display_if.slave  bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int RC_W  = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {
    IDLE,
    CONVERT
  } state_e;

  // Common-anode segment patterns. A value above 9 shows blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  state_e               state_q, state_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     shreg_q, shreg_d;
  logic [BCD_W-1:0]     work_q, work_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic [WIDTH-1:0]     pend_val_q, pend_val_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic                 bcd_valid_q, bcd_valid_d;
  logic                 busy_q, busy_d;
  logic [RC_W-1:0]      ref_cnt_q, ref_cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [6:0]           seg_q, seg_d;
  logic [DIGITS-1:0]    an_q, an_d;

  logic                 start;
  logic [BCD_W-1:0]     work_adj;
  logic [BCD_W+WIDTH-1:0] shifted;
  logic [DIGITS-1:0]    lz;
  logic [3:0]           digit;
  logic                 blank;

  // One double-dabble step. Each nibble of 5 or more gets +3. Then the
  // BCD/binary pair shifts left by one bit.
  always_comb begin
    // NOTE: each always_comb output gets a default before any branch. A path
    // that leaves it unassigned would infer a latch.
    work_adj = work_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (work_q[4*k +: 4] >= 4'd5) work_adj[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
    end
    shifted = {work_adj, shreg_q} << 1;
  end

  // Edge detect, conversion FSM, and the one-deep pending slot.
  always_comb begin
    done_d      = bus.done;
    start       = bus.done & ~done_q;
    state_d     = state_q;
    shreg_d     = shreg_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_val_d  = pend_val_q;
    bcd_d       = bcd_q;
    bcd_valid_d = 1'b0;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        // A fresh edge takes priority over an older pending value.
        if (start || pend_q) begin
          shreg_d = start ? bus.result : pend_val_q;
          work_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          pend_d  = 1'b0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        if (start) begin
          pend_val_d = bus.result;
          pend_d     = 1'b1;
        end
        work_d  = shifted[BCD_W+WIDTH-1:WIDTH];
        shreg_d = shifted[WIDTH-1:0];
        cnt_d   = cnt_q + 1'b1;
        // bcd changes only here, so it never shows a partial conversion.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          bcd_d       = shifted[BCD_W+WIDTH-1:WIDTH];
          bcd_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
    endcase
  end

  // Display refresh: advance to the next digit when the prescaler wraps.
  // an and seg are both computed from idx_d, so they change on the same edge.
  always_comb begin
    logic zero_run;
    ref_cnt_d = ref_cnt_q + 1'b1;
    idx_d     = idx_q;
    if (ref_cnt_q == RC_W'(REFRESH_DIV - 1)) begin
      ref_cnt_d = '0;
      idx_d     = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end

    // lz[k] is set when digit k and every digit above it are zero.
    zero_run = 1'b1;
    lz       = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (bcd_q[4*k +: 4] == 4'd0);
      lz[k]    = zero_run;
    end

    digit = bcd_q[4*int'(idx_d) +: 4];
    blank = (BLANK_LZ != 0) && (idx_d != '0) && lz[idx_d];
    seg_d = blank ? 7'h7F : seg_decode(digit);
    an_d  = ~(DIGITS'(1) << idx_d);
  end

  // NOTE: rst is synchronous. It is sampled only at the clock edge, so it is
  // not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments. Every flop then
      // sees the values from before the edge.
      state_q     <= IDLE;
      done_q      <= 1'b0;
      shreg_q     <= '0;
      work_q      <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_val_q  <= '0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ref_cnt_q   <= '0;
      idx_q       <= '0;
      seg_q       <= 7'h40;
      an_q        <= ~DIGITS'(1);
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      shreg_q     <= shreg_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_val_q  <= pend_val_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= bcd_valid_d;
      busy_q      <= busy_d;
      ref_cnt_q   <= ref_cnt_d;
      idx_q       <= idx_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign bus.bcd       = bcd_q;
  assign bus.bcd_valid = bcd_valid_q;
  assign bus.busy      = busy_q;
  assign bus.seg       = seg_q;
  assign bus.an        = an_q;

endmodule

// File: tb/tb_mult_display.sv
// Testbench: tb_mult_display
// Issues done edges with random and directed products. Each expected BCD
// value is computed arithmetically from the product and queued. A monitor pops
// one entry and compares it on every bcd_valid pulse. Timing, reset and
// display multiplexing are checked directly.
module tb_mult_display;
  localparam int WIDTH       = 6;
  localparam int DIGITS      = 2;
  localparam int REFRESH_DIV = 4;
  localparam int BLANK_LZ    = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_display_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  mult_display #(
    .WIDTH(WIDTH), .DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV), .BLANK_LZ(BLANK_LZ)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [4*DIGITS-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal digits by plain division.
  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int div;
    r   = '0;
    div = 1;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'((v / div) % 10);
      div = div * 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] tab [10];
    tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return tab[d];
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.bcd_valid === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_bcd_valid", 32'(bus.bcd_valid), 32'd0);
      else                   check("bcd", 32'(bus.bcd), 32'(exp_q.pop_front()));
    end
  end

  // Raise done for one cycle. The posedge after the first negedge is the
  // capture edge E0. Returns at the negedge just after E0.
  task automatic pulse(input int v, input bit expect_it);
    @(negedge clk);
    bus.result = WIDTH'(v);
    bus.done   = 1'b1;
    if (expect_it) exp_q.push_back(to_bcd(v));
    @(negedge clk);
    bus.done = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || bus.busy !== 1'b0) && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [DIGITS-1:0] cur, exp_an;
    logic [4*DIGITS-1:0] b63;
    int v, v2;

    // 1: reset values, then the blanked tens digit.
    rst = 1'b1; bus.done = 1'b0; bus.result = '0;
    repeat (2) @(negedge clk);
    check("rst_bcd", 32'(bus.bcd), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_valid", 32'(bus.bcd_valid), 32'd0);
    check("rst_an", 32'(bus.an), 32'b10);
    check("rst_seg", 32'(bus.seg), 32'h40);
    rst = 1'b0;
    for (int i = 0; i < 12 && bus.an !== 2'b01; i++) @(negedge clk);
    check("lz_an", 32'(bus.an), 32'b01);
    check("lz_seg", 32'(bus.seg), 32'h7F);

    // 2: latency of a single conversion of 15.
    pulse(15, 1'b1);  // now after E0
    for (int i = 1; i <= 6; i++) begin
      check("lat_busy", 32'(bus.busy), 32'd1);
      check("lat_valid", 32'(bus.bcd_valid), 32'd0);
      @(negedge clk);
    end
    check("lat_busy_end", 32'(bus.busy), 32'd0);
    check("lat_valid_end", 32'(bus.bcd_valid), 32'd1);
    check("lat_bcd", 32'(bus.bcd), 32'h15);
    wait_idle(40);

    // 3: second product arrives during busy and is serviced after the first.
    pulse(49, 1'b1);
    pulse(63, 1'b1);
    wait_idle(60);

    // The pending slot is one deep; the newest edge replaces the older one.
    pulse(7, 1'b1);
    pulse(22, 1'b0);
    pulse(58, 1'b1);
    wait_idle(60);

    // 4: full sweep.
    for (int i = 0; i < 64; i++) begin
      pulse(i, 1'b1);
      wait_idle(40);
    end

    // Random products, sometimes with a second product arriving during busy.
    for (int i = 0; i < 30; i++) begin
      v = int'($urandom_range(0, 63));
      repeat ($urandom_range(0, 5)) @(negedge clk);
      pulse(v, 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        v2 = int'($urandom_range(0, 63));
        pulse(v2, 1'b1);
      end
      wait_idle(60);
    end

    // 5: multiplexing of 63.
    pulse(63, 1'b1);
    wait_idle(40);
    repeat (3) @(negedge clk);
    cur = bus.an;
    for (int i = 0; i < 8 && bus.an === cur; i++) @(negedge clk);
    cur = bus.an;
    b63 = to_bcd(63);
    for (int i = 0; i < 8; i++) begin
      exp_an = (i < 4) ? cur : ~cur;
      check("mux_an", 32'(bus.an), 32'(exp_an));
      check("mux_seg", 32'(bus.seg),
            32'(seg_of(int'(exp_an == 2'b10 ? b63[3:0] : b63[7:4]))));
      @(negedge clk);
    end

    // 6: reset in the middle of converting 49.
    pulse(49, 1'b0);      // after E0
    @(negedge clk);       // after E0+1
    @(negedge clk);       // after E0+2
    rst = 1'b1;           // sampled at E0+3
    @(negedge clk);
    rst = 1'b0;
    check("abort_bcd", 32'(bus.bcd), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_an", 32'(bus.an), 32'b10);
    check("abort_seg", 32'(bus.seg), 32'h40);
    repeat (10) @(negedge clk);
    check("abort_idle", 32'(bus.busy), 32'd0);
    pulse(49, 1'b1);
    wait_idle(40);
    check("after_abort_bcd", 32'(bus.bcd), 32'h49);

    // done held high through reset release counts as an edge.
    @(negedge clk);
    rst = 1'b1; bus.result = WIDTH'(37); bus.done = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.push_back(to_bcd(37));
    rst = 1'b0;
    @(negedge clk);
    check("held_done_busy", 32'(bus.busy), 32'd1);
    bus.done = 1'b0;
    wait_idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
